// File: rtl/gpio_arbiter.sv
// gpio_arbiter
//   Two-requester round-robin arbiter in front of a single GPIO command port.
//   A transaction takes three cycles. In IDLE the winning request is granted
//   combinationally and its fields are latched. ISSUE drives one GPIO command
//   strobe. CAPT registers the GPIO return data, and the owner sees rvalid on
//   the following cycle.
//
//   Optional feature macro: GPIO_ARB_LOCK_EN
//     When defined, m0_lock/m1_lock let the current owner keep the priority
//     pointer for up to LOCK_MAX consecutive transactions.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   mN_req/we/sel/wdata    request from requester N (sel: 0 = LED, 1 = button)
//   mN_lock                lock continuation (GPIO_ARB_LOCK_EN only)
//   mN_gnt                 request accepted this cycle (pulse)
//   mN_rvalid              response for requester N (pulse)
//   rdata                  shared response data, held until the next capture
//   valid/we/sel_led/sel_but/data_m  GPIO command outputs
//   data_s                 registered GPIO return data
module gpio_arbiter #(
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       m0_we,
  input  logic       m1_we,
  input  logic       m0_sel,
  input  logic       m1_sel,
  input  logic [3:0] m0_wdata,
  input  logic [3:0] m1_wdata,
`ifdef GPIO_ARB_LOCK_EN
  input  logic       m0_lock,
  input  logic       m1_lock,
`endif
  output logic       m0_gnt,
  output logic       m1_gnt,
  output logic       m0_rvalid,
  output logic       m1_rvalid,
  output logic [3:0] rdata,
  output logic       valid,
  output logic       we,
  output logic       sel_led,
  output logic       sel_but,
  output logic [3:0] data_m,
  input  logic [3:0] data_s
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2
  } state_e;

  state_e     state_q;
  logic       ptr_q;
  logic       owner_q;
  logic       we_q;
  logic       sel_q;
  logic [3:0] wdata_q;
  logic [3:0] rdata_q;
  logic       rvalid0_q;
  logic       rvalid1_q;

  logic       any_req_s;
  logic       pick_s;
  logic       grant_s;
  logic       issue_s;
  logic       we_d;
  logic       sel_d;
  logic [3:0] wdata_d;
  logic       ptr_d;

`ifdef GPIO_ARB_LOCK_EN
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_MAX - 1);
  logic [3:0] lock_cnt_q;
  logic [3:0] lock_cnt_d;
  logic       owner_lock_s;
`endif

  // Round-robin pick: the favoured requester wins, otherwise the other one.
  always_comb begin
    any_req_s = m0_req | m1_req;
    if (ptr_q == 1'b0) begin
      if (m0_req) pick_s = 1'b0;
      else        pick_s = 1'b1;
    end else begin
      if (m1_req) pick_s = 1'b1;
      else        pick_s = 1'b0;
    end
    if (pick_s == 1'b1) begin
      we_d    = m1_we;
      sel_d   = m1_sel;
      wdata_d = m1_wdata;
    end else begin
      we_d    = m0_we;
      sel_d   = m0_sel;
      wdata_d = m0_wdata;
    end
  end

  // Pointer (and lock count) to apply when the current transaction completes.
  always_comb begin
    ptr_d = ~owner_q;
`ifdef GPIO_ARB_LOCK_EN
    lock_cnt_d   = 4'd0;
    if (owner_q == 1'b1) owner_lock_s = m1_lock;
    else                 owner_lock_s = m0_lock;
    // A locked owner keeps priority until LOCK_MAX transactions have run.
    if (owner_lock_s && (lock_cnt_q < LOCK_LAST)) begin
      ptr_d      = owner_q;
      lock_cnt_d = lock_cnt_q + 4'd1;
    end else begin
      ptr_d      = ~owner_q;
      lock_cnt_d = 4'd0;
    end
`endif
  end

  // Transaction FSM with latched request fields and registered responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 1'b0;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= 1'b0;
      wdata_q   <= 4'd0;
      rdata_q   <= 4'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
`ifdef GPIO_ARB_LOCK_EN
      lock_cnt_q <= 4'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          rvalid0_q <= 1'b0;
          rvalid1_q <= 1'b0;
          if (any_req_s) begin
            owner_q <= pick_s;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            state_q <= ST_ISSUE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          rvalid0_q <= 1'b0;
          rvalid1_q <= 1'b0;
          state_q   <= ST_CAPT;
        end
        ST_CAPT: begin
          rdata_q   <= data_s;
          rvalid0_q <= ~owner_q;
          rvalid1_q <= owner_q;
          ptr_q     <= ptr_d;
`ifdef GPIO_ARB_LOCK_EN
          lock_cnt_q <= lock_cnt_d;
`endif
          state_q   <= ST_IDLE;
        end
        default: begin
          rvalid0_q <= 1'b0;
          rvalid1_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  // Grants and GPIO strobes are forced low while reset is held.
  assign grant_s = (state_q == ST_IDLE) & any_req_s & ~rst_i;
  assign issue_s = (state_q == ST_ISSUE) & ~rst_i;

  assign m0_gnt    = grant_s & ~pick_s;
  assign m1_gnt    = grant_s & pick_s;
  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign rdata     = rdata_q;
  assign valid     = issue_s;
  assign we        = issue_s & we_q;
  assign sel_led   = issue_s & ~sel_q;
  assign sel_but   = issue_s & sel_q;
  assign data_m    = {4{issue_s}} & wdata_q;

endmodule

// File: tb/tb_gpio_arbiter.sv
module tb_gpio_arbiter;

  localparam int LMAX = 4;

  logic       clk;
  logic       rst, req0, req1, we0, we1, sel0, sel1, lk0, lk1;
  logic [3:0] wd0, wd1, ds;
  logic       g0_o, g1_o, rv0_o, rv1_o, valid_o, we_o, sl_o, sb_o;
  logic [3:0] rdata_o, dm_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [15:0] last_got;

  gpio_arbiter #(.LOCK_MAX(LMAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req(req0), .m1_req(req1), .m0_we(we0), .m1_we(we1),
    .m0_sel(sel0), .m1_sel(sel1), .m0_wdata(wd0), .m1_wdata(wd1),
`ifdef GPIO_ARB_LOCK_EN
    .m0_lock(lk0), .m1_lock(lk1),
`endif
    .m0_gnt(g0_o), .m1_gnt(g1_o), .m0_rvalid(rv0_o), .m1_rvalid(rv1_o),
    .rdata(rdata_o), .valid(valid_o), .we(we_o), .sel_led(sl_o),
    .sel_but(sb_o), .data_m(dm_o), .data_s(ds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: {g0,g1,rv0,rv1,valid,we,sel_led,sel_but,rdata,data_m}
  function automatic logic [15:0] mk(bit g0, bit g1, bit r0, bit r1, bit v, bit w,
                                     bit sl, bit sb, logic [3:0] rd, logic [3:0] dm);
    return {g0, g1, r0, r1, v, w, sl, sb, rd, dm};
  endfunction

  // ---------------- reference model (transaction level) ----------------
  int         m_age;    // 0 = free, 1 = command cycle, 2 = capture cycle
  bit         m_ptr, m_own, m_we, m_sel;
  logic [3:0] m_wd, m_rdata;
  int         m_rv;     // requester whose response is shown now, -1 none
  int         m_burst;  // locked transactions already run by the owner

  function automatic bit winner();
    bit [1:0] rq;
    rq = {req1, req0};
    return rq[m_ptr] ? m_ptr : !m_ptr;
  endfunction

  function automatic logic [15:0] model_out();
    bit g0 = 0, g1 = 0, v;
    if (!rst && m_age == 0 && (req0 || req1)) begin
      if (winner()) g1 = 1; else g0 = 1;
    end
    v = !rst && m_age == 1;
    return mk(g0, g1, m_rv == 0, m_rv == 1, v, v && m_we, v && !m_sel,
              v && m_sel, m_rdata, v ? m_wd : 4'h0);
  endfunction

  function automatic void model_step();
    bit lock_now;
    if (rst) begin
      m_age = 0; m_ptr = 0; m_own = 0; m_we = 0; m_sel = 0;
      m_wd = 4'h0; m_rdata = 4'h0; m_rv = -1; m_burst = 0;
      return;
    end
    m_rv = -1;
    if (m_age == 0) begin
      if (req0 || req1) begin
        m_own = winner();
        m_we  = m_own ? we1 : we0;
        m_sel = m_own ? sel1 : sel0;
        m_wd  = m_own ? wd1 : wd0;
        m_age = 1;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else begin
      m_rdata = ds;
      m_rv    = m_own;
`ifdef GPIO_ARB_LOCK_EN
      lock_now = m_own ? lk1 : lk0;
`else
      lock_now = 0;
`endif
      if (lock_now && (m_burst + 1) < LMAX) begin
        m_burst = m_burst + 1;
        m_ptr   = m_own;
      end else begin
        m_burst = 0;
        m_ptr   = !m_own;
      end
      m_age = 0;
    end
  endfunction

  // One cycle: inputs are already driven; compare mid-cycle, then advance.
  task automatic tick(input string name, input bit use_exp, input logic [15:0] exp);
    logic [15:0] got, want;
    #4;
    got  = {g0_o, g1_o, rv0_o, rv1_o, valid_o, we_o, sl_o, sb_o, rdata_o, dm_o};
    want = use_exp ? exp : model_out();
    last_got = got;
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, got, want);
    end
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic quiet();
    rst = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; sel0 = 0; sel1 = 0;
    wd0 = 4'h0; wd1 = 4'h0; ds = 4'h0; lk0 = 0; lk1 = 0;
  endtask

  typedef struct {
    logic       rst, r0, r1, we0, we1, s0, s1;
    logic [3:0] wd0, wd1, ds;
    logic [15:0] exp;
  } vec_t;

  function automatic vec_t vec(logic r, logic a0, logic a1, logic w0, logic w1,
                               logic s0, logic s1, logic [3:0] d0, logic [3:0] d1,
                               logic [3:0] dsv, logic [15:0] e);
    vec_t v;
    v.rst = r; v.r0 = a0; v.r1 = a1; v.we0 = w0; v.we1 = w1; v.s0 = s0; v.s1 = s1;
    v.wd0 = d0; v.wd1 = d1; v.ds = dsv; v.exp = e;
    return v;
  endfunction

  vec_t tbl[17];
  int   gq[$];

  initial begin
    // directed table: LED write, button read with held rdata, reset in ISSUE
    tbl[0]  = vec(1,0,0,0,0,0,0,4'h0,4'h0,4'h0, mk(0,0,0,0,0,0,0,0,4'h0,4'h0));
    tbl[1]  = vec(0,1,0,1,0,0,0,4'hA,4'h0,4'h0, mk(1,0,0,0,0,0,0,0,4'h0,4'h0));
    tbl[2]  = vec(0,0,0,0,0,0,0,4'h0,4'h0,4'h0, mk(0,0,0,0,1,1,1,0,4'h0,4'hA));
    tbl[3]  = vec(0,0,0,0,0,0,0,4'h0,4'h0,4'h3, mk(0,0,0,0,0,0,0,0,4'h0,4'h0));
    tbl[4]  = vec(0,0,1,0,0,0,1,4'h0,4'hF,4'h0, mk(0,1,1,0,0,0,0,0,4'h3,4'h0));
    tbl[5]  = vec(0,0,0,0,0,0,0,4'h0,4'h0,4'h0, mk(0,0,0,0,1,0,0,1,4'h3,4'hF));
    tbl[6]  = vec(0,0,0,0,0,0,0,4'h0,4'h0,4'h5, mk(0,0,0,0,0,0,0,0,4'h3,4'h0));
    tbl[7]  = vec(0,0,0,0,0,0,0,4'h0,4'h0,4'h0, mk(0,0,0,1,0,0,0,0,4'h5,4'h0));
    tbl[8]  = vec(0,0,0,0,0,0,0,4'h0,4'h0,4'h0, mk(0,0,0,0,0,0,0,0,4'h5,4'h0));
    tbl[9]  = vec(0,0,0,0,0,0,0,4'h0,4'h0,4'h0, mk(0,0,0,0,0,0,0,0,4'h5,4'h0));
    tbl[10] = vec(0,0,1,0,1,0,0,4'h0,4'h6,4'h0, mk(0,1,0,0,0,0,0,0,4'h5,4'h0));
    tbl[11] = vec(1,0,0,0,0,0,0,4'h0,4'h0,4'h0, mk(0,0,0,0,0,0,0,0,4'h5,4'h0));
    tbl[12] = vec(0,0,1,0,0,0,1,4'h0,4'h2,4'h0, mk(0,1,0,0,0,0,0,0,4'h0,4'h0));
    tbl[13] = vec(0,0,0,0,0,0,0,4'h0,4'h0,4'h0, mk(0,0,0,0,1,0,0,1,4'h0,4'h2));
    tbl[14] = vec(0,0,0,0,0,0,0,4'h0,4'h0,4'h9, mk(0,0,0,0,0,0,0,0,4'h0,4'h0));
    tbl[15] = vec(0,0,0,0,0,0,0,4'h0,4'h0,4'h0, mk(0,0,0,1,0,0,0,0,4'h9,4'h0));
    tbl[16] = vec(0,0,0,0,0,0,0,4'h0,4'h0,4'h0, mk(0,0,0,0,0,0,0,0,4'h9,4'h0));

    quiet();
    rst = 1;
    repeat (2) begin @(posedge clk); model_step(); #1; end

    for (int i = 0; i < 17; i++) begin
      rst = tbl[i].rst; req0 = tbl[i].r0; req1 = tbl[i].r1;
      we0 = tbl[i].we0; we1 = tbl[i].we1; sel0 = tbl[i].s0; sel1 = tbl[i].s1;
      wd0 = tbl[i].wd0; wd1 = tbl[i].wd1; ds = tbl[i].ds;
      tick("table", 1, tbl[i].exp);
    end

    // simultaneous requests from reset: m0, m1, m0 at cycles 0, 3, 6
    quiet(); rst = 1;
    tick("rr_reset", 0, 16'h0);
    rst = 0; req0 = 1; req1 = 1;
    tick("rr_c0", 1, mk(1,0,0,0,0,0,0,0,4'h0,4'h0));
    tick("rr_c1", 1, mk(0,0,0,0,1,0,1,0,4'h0,4'h0));
    tick("rr_c2", 1, mk(0,0,0,0,0,0,0,0,4'h0,4'h0));
    tick("rr_c3", 1, mk(0,1,1,0,0,0,0,0,4'h0,4'h0));
    tick("rr_c4", 1, mk(0,0,0,0,1,0,1,0,4'h0,4'h0));
    tick("rr_c5", 1, mk(0,0,0,0,0,0,0,0,4'h0,4'h0));
    tick("rr_c6", 1, mk(1,0,0,1,0,0,0,0,4'h0,4'h0));
    req0 = 0; req1 = 0;
    repeat (3) tick("rr_drain", 0, 16'h0);

    // idle bench: nothing moves for 20 cycles after reset
    quiet(); rst = 1;
    tick("idle_reset", 0, 16'h0);
    rst = 0;
    repeat (20) tick("idle", 1, 16'h0);

`ifdef GPIO_ARB_LOCK_EN
    // locked m0 keeps the port for LMAX transactions, then m1 gets it
    quiet(); rst = 1;
    tick("lock_reset", 0, 16'h0);
    rst = 0; req0 = 1; req1 = 1; lk0 = 1;
    for (int c = 0; c < 13; c++) begin
      tick("lock_seq", 0, 16'h0);
      if (last_got[15]) gq.push_back(0);
      if (last_got[14]) gq.push_back(1);
    end
    total++;
    if (gq.size() != 5 || gq[0] != 0 || gq[1] != 0 || gq[2] != 0 || gq[3] != 0 || gq[4] != 1) begin
      bad++;
      $display("FAIL lock_order got=%p want='{0,0,0,0,1}", gq);
    end
    quiet();
    repeat (3) tick("lock_drain", 0, 16'h0);
`endif

    // randomized traffic against the model
    quiet(); rst = 1;
    tick("rand_reset", 0, 16'h0);
    for (int c = 0; c < 600; c++) begin
      rst  = ($urandom_range(0, 49) == 0);
      req0 = ($urandom_range(0, 2) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      we0  = 1'($urandom); we1 = 1'($urandom);
      sel0 = 1'($urandom); sel1 = 1'($urandom);
      wd0  = 4'($urandom); wd1 = 4'($urandom); ds = 4'($urandom);
      lk0  = ($urandom_range(0, 3) != 0);
      lk1  = ($urandom_range(0, 3) != 0);
      tick("random", 0, 16'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
